// File: rtl/cmplx_mul_seq.sv
// Sequential complex multiplier: computes A*B with four products from one external
// shared multiplier, accumulating real and imaginary parts at 2N+1 bits.
//
// state | meaning
// IDLE  | waiting for Start; Busy=0
// LOAD  | Mul_Ld pulse for product k
// WAIT  | waiting for Mul_Valid of product k
// DONE  | Pr/Pi valid, Done=1, new Start accepted
module cmplx_mul_seq #(
  parameter int N = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic                Abort,
  input  logic signed [N-1:0] Ar,
  input  logic signed [N-1:0] Ai,
  input  logic signed [N-1:0] Br,
  input  logic signed [N-1:0] Bi,
  output logic                Busy,
  output logic                Done,
  output logic signed [2*N:0] Pr,
  output logic signed [2*N:0] Pi,
  output logic                Mul_Ld,
  output logic [N-1:0]        Mul_M,
  output logic [N-1:0]        Mul_R,
  input  logic                Mul_Valid,
  input  logic [2*N-1:0]      Mul_P
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_k;
  logic [1:0]          w_k_nxt;
  logic                w_accept;
  logic                w_step;
  logic signed [N-1:0] r_ar;
  logic signed [N-1:0] r_ai;
  logic signed [N-1:0] r_br;
  logic signed [N-1:0] r_bi;
  logic signed [2*N:0] r_acc_re;
  logic signed [2*N:0] r_acc_im;
  logic signed [2*N:0] w_p_ext;
  logic signed [2*N:0] w_im_final;

  assign w_p_ext    = {Mul_P[2*N-1], Mul_P};
  assign w_im_final = r_acc_im + w_p_ext;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    Mul_Ld      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        Done = (r_state == S_DONE);
        if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
          w_k_nxt     = 2'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        Busy   = 1'b1;
        Mul_Ld = 1'b1;
        if (Abort) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 2'd0;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        Busy = 1'b1;
        // Abort wins over a product arriving in the same cycle
        if (Abort) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 2'd0;
        end else if (Mul_Valid) begin
          w_step = 1'b1;
          if (r_k == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
            w_k_nxt     = r_k + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand selection follows k; captured operands keep it stable through each product
  always_comb begin
    Mul_M = r_ar;
    Mul_R = r_br;
    case (r_k)
      2'd0: begin Mul_M = r_ar; Mul_R = r_br; end
      2'd1: begin Mul_M = r_ai; Mul_R = r_bi; end
      2'd2: begin Mul_M = r_ar; Mul_R = r_bi; end
      2'd3: begin Mul_M = r_ai; Mul_R = r_br; end
      default: begin Mul_M = r_ar; Mul_R = r_br; end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ar     <= '0;
      r_ai     <= '0;
      r_br     <= '0;
      r_bi     <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      Pr       <= '0;
      Pi       <= '0;
    end else begin
      if (w_accept) begin
        r_ar <= Ar;
        r_ai <= Ai;
        r_br <= Br;
        r_bi <= Bi;
      end
      if (w_step) begin
        case (r_k)
          2'd0: r_acc_re <= w_p_ext;
          2'd1: r_acc_re <= r_acc_re - w_p_ext;
          2'd2: r_acc_im <= w_p_ext;
          2'd3: begin
            r_acc_im <= w_im_final;
            Pr       <= r_acc_re;
            Pi       <= w_im_final;
          end
          default: r_acc_re <= r_acc_re;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmplx_mul_seq.sv
// Bench for cmplx_mul_seq: exact multiplier model with programmable latency,
// directed scenarios plus randomized operations checked against complex arithmetic.
module tb_cmplx_mul_seq;
  localparam int N = 16;

  logic                Clk = 1'b0;
  logic                Rst_n = 1'b0;
  logic                Start = 1'b0;
  logic                Abort = 1'b0;
  logic signed [N-1:0] Ar = '0;
  logic signed [N-1:0] Ai = '0;
  logic signed [N-1:0] Br = '0;
  logic signed [N-1:0] Bi = '0;
  logic                Busy;
  logic                Done;
  logic signed [2*N:0] Pr;
  logic signed [2*N:0] Pi;
  logic                Mul_Ld;
  logic [N-1:0]        Mul_M;
  logic [N-1:0]        Mul_R;
  logic                Mul_Valid = 1'b0;
  logic [2*N-1:0]      Mul_P = '0;

  cmplx_mul_seq #(.N(N)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi),
    .Busy(Busy), .Done(Done), .Pr(Pr), .Pi(Pi),
    .Mul_Ld(Mul_Ld), .Mul_M(Mul_M), .Mul_R(Mul_R),
    .Mul_Valid(Mul_Valid), .Mul_P(Mul_P)
  );

  always #5 Clk = ~Clk;

  int     cyc = 0;
  int     vectors = 0;
  int     errors = 0;
  int     lat = 9;
  int     cnt = 0;
  int     ld_count = 0;
  bit     spur = 1'b0;
  longint prod = 0;
  longint ld_m[$];
  longint ld_r[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Multiplier model: Mul_Ld seen in cycle c gives Mul_Valid in cycle c+lat
  always @(negedge Clk) begin
    Mul_Valid = 1'b0;
    if (spur) begin
      Mul_Valid = 1'b1;
      Mul_P     = (2*N)'($urandom);
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        Mul_Valid = 1'b1;
        Mul_P     = prod[2*N-1:0];
      end
    end
    if (Mul_Ld === 1'b1) begin
      cnt  = lat;
      prod = longint'($signed(Mul_M)) * longint'($signed(Mul_R));
      ld_count = ld_count + 1;
      ld_m.push_back(longint'($signed(Mul_M)));
      ld_r.push_back(longint'($signed(Mul_R)));
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_re(longint ar, longint ai, longint br, longint bi);
    return ar * br - ai * bi;
  endfunction

  function automatic longint ref_im(longint ar, longint ai, longint br, longint bi);
    return ar * bi + ai * br;
  endfunction

  task automatic scramble();
    Ar = N'($urandom);
    Ai = N'($urandom);
    Br = N'($urandom);
    Bi = N'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit scr, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
      if (scr) scramble();
    end
  endtask

  task automatic wait_ld(input int target, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ld_count >= target) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic chk_order(input string tag, input longint ar, input longint ai,
                           input longint br, input longint bi);
    longint em[4];
    longint er[4];
    em = '{ar, ai, ar, ai};
    er = '{br, bi, bi, br};
    chk({tag, "_ldq"}, longint'(ld_m.size()), 4);
    if (ld_m.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s_m%0d", tag, j), ld_m[j], em[j]);
        chk($sformatf("%s_r%0d", tag, j), ld_r[j], er[j]);
      end
    end
  endtask

  // Called at a negedge with the DUT idle; checks result, latency and multiplier traffic
  task automatic run_op(input logic signed [N-1:0] ar, input logic signed [N-1:0] ai,
                        input logic signed [N-1:0] br, input logic signed [N-1:0] bi,
                        input int L, input string tag);
    int     t0;
    int     base;
    bit     found;
    longint pr_exp;
    longint pi_exp;
    pr_exp = ref_re(longint'(ar), longint'(ai), longint'(br), longint'(bi));
    pi_exp = ref_im(longint'(ar), longint'(ai), longint'(br), longint'(bi));
    lat  = L;
    base = ld_count;
    ld_m.delete();
    ld_r.delete();
    Ar = ar; Ai = ai; Br = br; Bi = bi;
    Start = 1'b1;
    t0 = cyc;
    @(negedge Clk);
    Start = 1'b0;
    scramble();
    chk({tag, "_busy"}, longint'(Busy), 1);
    wait_done(4 * (L + 1) + 20, 1'b1, found);
    chk({tag, "_done_seen"}, longint'(found), 1);
    if (found) begin
      chk({tag, "_latency"}, longint'(cyc - t0), longint'(4 * (L + 1) + 1));
      chk({tag, "_pr"}, longint'(Pr), pr_exp);
      chk({tag, "_pi"}, longint'(Pi), pi_exp);
      chk({tag, "_busy_in_done"}, longint'(Busy), 0);
      chk({tag, "_ld_pulses"}, longint'(ld_count - base), 4);
      chk_order(tag, longint'(ar), longint'(ai), longint'(br), longint'(bi));
      @(negedge Clk);
      chk({tag, "_done_1cyc"}, longint'(Done), 0);
      chk({tag, "_pr_hold"}, longint'(Pr), pr_exp);
    end
  endtask

  initial begin
    bit     found;
    int     t0;
    int     base;
    int     done_seen;
    longint pr_prev;
    longint pi_prev;
    logic signed [N-1:0] a1r, a1i, b1r, b1i, a2r, a2i, b2r, b2i;

    #2;
    chk("rst_busy", longint'(Busy), 0);
    chk("rst_done", longint'(Done), 0);
    chk("rst_ld", longint'(Mul_Ld), 0);
    chk("rst_pr", longint'(Pr), 0);
    chk("rst_pi", longint'(Pi), 0);
    chk("rst_mulm", longint'(Mul_M), 0);
    chk("rst_mulr", longint'(Mul_R), 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    run_op(16'sd3, 16'sd4, 16'sd5, -16'sd2, 9, "basic");
    chk("basic_pr_const", longint'(Pr), 23);
    chk("basic_pi_const", longint'(Pi), 14);

    run_op(-16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767, 9, "extreme");
    chk("extreme_pr_const", longint'(Pr), 2147450880);
    chk("extreme_pi_const", longint'(Pi), 32768);
    run_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 9, "allneg");

    // Start held high: ignored while busy, accepted again in the Done cycle
    lat = 9;
    a1r = N'($urandom); a1i = N'($urandom); b1r = N'($urandom); b1i = N'($urandom);
    a2r = N'($urandom); a2i = N'($urandom); b2r = N'($urandom); b2i = N'($urandom);
    Ar = a1r; Ai = a1i; Br = b1r; Bi = b1i;
    Start = 1'b1;
    t0 = cyc;
    @(negedge Clk);
    Ar = a2r; Ai = a2i; Br = b2r; Bi = b2i;
    wait_done(80, 1'b0, found);
    chk("held_done1", longint'(found), 1);
    if (found) begin
      chk("held_lat1", longint'(cyc - t0), 41);
      chk("held_pr1", longint'(Pr), ref_re(a1r, a1i, b1r, b1i));
      chk("held_pi1", longint'(Pi), ref_im(a1r, a1i, b1r, b1i));
      t0 = cyc;
      @(negedge Clk);
      Start = 1'b0;
      chk("held_reaccept", longint'(Busy), 1);
      wait_done(80, 1'b1, found);
      chk("held_done2", longint'(found), 1);
      if (found) begin
        chk("held_lat2", longint'(cyc - t0), 41);
        chk("held_pr2", longint'(Pr), ref_re(a2r, a2i, b2r, b2i));
        chk("held_pi2", longint'(Pi), ref_im(a2r, a2i, b2r, b2i));
      end
    end
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);

    // Abort in WAIT at k=2
    run_op(16'sd1234, -16'sd77, 16'sd300, 16'sd45, 9, "pre_abort");
    pr_prev = longint'(Pr);
    pi_prev = longint'(Pi);
    lat  = 9;
    base = ld_count;
    scramble();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_ld(base + 3, 60, found);
    chk("abort_reach_k2", longint'(found), 1);
    @(negedge Clk);
    chk("abort_in_wait", longint'(Busy & ~Mul_Ld), 1);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_idle", longint'(Busy), 0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done === 1'b1) done_seen++;
      @(negedge Clk);
    end
    chk("abort_no_done", longint'(done_seen), 0);
    chk("abort_no_ld", longint'(ld_count - base), 3);
    chk("abort_pr_kept", longint'(Pr), pr_prev);
    chk("abort_pi_kept", longint'(Pi), pi_prev);
    run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 9, "post_abort");

    // Reset mid-WAIT, then a spurious product while idle
    lat  = 9;
    base = ld_count;
    Ar = 16'sd111; Ai = 16'sd222; Br = 16'sd333; Bi = 16'sd444;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_ld(base + 2, 60, found);
    chk("rst_reach_k1", longint'(found), 1);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("mrst_busy", longint'(Busy), 0);
    chk("mrst_done", longint'(Done), 0);
    chk("mrst_ld", longint'(Mul_Ld), 0);
    chk("mrst_mulm", longint'(Mul_M), 0);
    chk("mrst_mulr", longint'(Mul_R), 0);
    chk("mrst_pr", longint'(Pr), 0);
    chk("mrst_pi", longint'(Pi), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    spur = 1'b1;
    @(posedge Clk);
    spur = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) done_seen++;
    end
    chk("spur_ignored", longint'(done_seen), 0);
    chk("spur_pr", longint'(Pr), 0);
    chk("spur_pi", longint'(Pi), 0);
    run_op(16'sd111, 16'sd222, 16'sd333, 16'sd444, 9, "post_rst");

    run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1, "lat1");
    run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 9, "lat9");
    run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 17, "lat17");

    for (int n = 0; n < 12; n++) begin
      run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom),
             int'($urandom_range(1, 20)), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
